// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the programmable clock divider.
package clk_div_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_END, SETTLE} state_e;

  localparam int MIN_DIV = 2;

  // Ratio must be at least MIN_DIV and representable in cnt_w bits.
  function automatic bit div_fits(input int cnt_w, input int div);
    return (div >= MIN_DIV) && (longint'(div) < (longint'(1) << cnt_w));
  endfunction
endpackage

// File: rtl/clk_div_ctrl_if.sv
// Ratio-update handshake between the config logic and the divider controller.
interface clk_div_ctrl_if #(parameter int CNT_W = 8) ();
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;
  logic             cfg_done;

  modport master (output cfg_valid, cfg_div, input cfg_ready, cfg_err, cfg_done);
  modport slave  (input cfg_valid, cfg_div, output cfg_ready, cfg_err, cfg_done);
endinterface

// File: rtl/clk_div_core.sv
// Period counter and registered divided clock; load replaces ratio and count in one edge.
module clk_div_core #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] div_cur,
  output logic             div_out,
  output logic             tick
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_last;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_last = div_cur - CNT_W'(1);
  assign cnt_nxt  = (cnt == cnt_last) ? '0 : cnt + CNT_W'(1);
  assign tick     = en && (cnt == cnt_last);

  // Idle holds cnt at the last count so the first enabled edge begins at cnt=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= CNT_W'(DEFAULT_DIV - 1);
      div_cur <= CNT_W'(DEFAULT_DIV);
      div_out <= 1'b0;
    end else if (load) begin
      div_cur <= load_div;
      cnt     <= load_cnt;
      div_out <= en && (load_cnt < (load_div >> 1));
    end else if (!en) begin
      cnt     <= cnt_last;
      div_out <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      div_out <= (cnt_nxt < (div_cur >> 1));
    end
  end
endmodule

// File: rtl/clk_div_ctrl.sv
// Divider controller: accepts ratio updates and swaps them in only at a period boundary.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 5,
  parameter int SETTLE_CYC  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  clk_div_ctrl_if.slave    cfg,
  output logic             busy,
  output logic [CNT_W-1:0] div_cur,
  output logic             div_out,
  output logic             tick
);
  localparam int SCNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  if (!div_fits(CNT_W, DEFAULT_DIV) || SETTLE_CYC < 1) begin : g_bad_param
    $error("clk_div_ctrl: DEFAULT_DIV or SETTLE_CYC out of range");
  end

  state_e            st, st_nxt;
  logic [CNT_W-1:0]  pend, pend_nxt;
  logic [SCNT_W-1:0] scnt, scnt_nxt;
  logic              err_q, err_nxt;
  logic              done_q, done_nxt;
  logic              load;
  logic [CNT_W-1:0]  load_cnt;

  clk_div_core #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (load),
    .load_div (pend),
    .load_cnt (load_cnt),
    .div_cur  (div_cur),
    .div_out  (div_out),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      pend   <= CNT_W'(DEFAULT_DIV);
      scnt   <= '0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st     <= st_nxt;
      pend   <= pend_nxt;
      scnt   <= scnt_nxt;
      err_q  <= err_nxt;
      done_q <= done_nxt;
    end
  end

  always_comb begin
    st_nxt   = st;
    pend_nxt = pend;
    scnt_nxt = scnt;
    err_nxt  = 1'b0;
    done_nxt = 1'b0;
    load     = 1'b0;
    load_cnt = '0;
    case (st)
      IDLE: begin
        if (cfg.cfg_valid) begin
          pend_nxt = cfg.cfg_div;
          if (cfg.cfg_div < CNT_W'(MIN_DIV)) err_nxt = 1'b1;
          else                               st_nxt  = WAIT_END;
        end
      end
      WAIT_END: begin
        // Stopped divider has no boundary to wait for; park at the new last count.
        if (!en) begin
          load     = 1'b1;
          load_cnt = pend - CNT_W'(1);
          scnt_nxt = '0;
          st_nxt   = SETTLE;
        end else if (tick) begin
          load     = 1'b1;
          scnt_nxt = '0;
          st_nxt   = SETTLE;
        end
      end
      SETTLE: begin
        if (!en) begin
          done_nxt = 1'b1;
          st_nxt   = IDLE;
        end else if (tick) begin
          if (scnt == SCNT_W'(SETTLE_CYC - 1)) begin
            done_nxt = 1'b1;
            st_nxt   = IDLE;
          end else begin
            scnt_nxt = scnt + SCNT_W'(1);
          end
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign cfg.cfg_ready = (st == IDLE);
  assign cfg.cfg_err   = err_q;
  assign cfg.cfg_done  = done_q;
  assign busy          = (st != IDLE);
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: per-cycle vector table plus hand-written update corners.
module tb_clk_div_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       busy;
  logic [7:0] div_cur;
  logic       div_out;
  logic       tick;

  clk_div_ctrl_if #(.CNT_W(8)) cfg ();

  clk_div_ctrl #(.CNT_W(8), .DEFAULT_DIV(5), .SETTLE_CYC(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cfg     (cfg),
    .busy    (busy),
    .div_cur (div_cur),
    .div_out (div_out),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        v;
    logic [7:0]  div;
    logic [13:0] exp;
  } vec_t;

  vec_t tv[$];
  int   passed = 0;
  int   total  = 0;

  // {div_out, tick, cfg_ready, busy, div_cur, cfg_err, cfg_done}
  function automatic logic [13:0] pk(bit d, bit t, bit r, bit b, int dc, bit e, bit dn);
    return {d, t, r, b, 8'(dc), e, dn};
  endfunction

  function automatic logic [13:0] obs();
    return {div_out, tick, cfg.cfg_ready, busy, div_cur, cfg.cfg_err, cfg.cfg_done};
  endfunction

  function automatic vec_t mk(bit e, bit v, int div, bit d, bit t, bit r, bit b, int dc,
                              bit er, bit dn);
    vec_t x;
    x.en  = e;
    x.v   = v;
    x.div = 8'(div);
    x.exp = pk(d, t, r, b, dc, er, dn);
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int nd, nb, k;
    bit got;

    // ratio 5 free-running, then update to 4 accepted at cnt=1
    tv.push_back(mk(1,0,0, 0,1,1,0,5,0,0));
    tv.push_back(mk(1,0,0, 1,0,1,0,5,0,0));
    tv.push_back(mk(1,0,0, 1,0,1,0,5,0,0));
    tv.push_back(mk(1,0,0, 0,0,1,0,5,0,0));
    tv.push_back(mk(1,0,0, 0,0,1,0,5,0,0));
    tv.push_back(mk(1,0,0, 0,1,1,0,5,0,0));
    tv.push_back(mk(1,0,0, 1,0,1,0,5,0,0));
    tv.push_back(mk(1,1,4, 1,0,1,0,5,0,0));
    tv.push_back(mk(1,0,0, 0,0,0,1,5,0,0));
    tv.push_back(mk(1,0,0, 0,0,0,1,5,0,0));
    tv.push_back(mk(1,0,0, 0,1,0,1,5,0,0));
    tv.push_back(mk(1,0,0, 1,0,0,1,4,0,0));
    tv.push_back(mk(1,0,0, 1,0,0,1,4,0,0));
    tv.push_back(mk(1,0,0, 0,0,0,1,4,0,0));
    tv.push_back(mk(1,0,0, 0,1,0,1,4,0,0));
    tv.push_back(mk(1,0,0, 1,0,0,1,4,0,0));
    tv.push_back(mk(1,0,0, 1,0,0,1,4,0,0));
    tv.push_back(mk(1,0,0, 0,0,0,1,4,0,0));
    tv.push_back(mk(1,0,0, 0,1,0,1,4,0,0));
    tv.push_back(mk(1,0,0, 1,0,1,0,4,0,1));
    // illegal ratios 1 and 0
    tv.push_back(mk(1,1,1, 1,0,1,0,4,0,0));
    tv.push_back(mk(1,0,0, 0,0,1,0,4,1,0));
    tv.push_back(mk(1,1,0, 0,1,1,0,4,0,0));
    tv.push_back(mk(1,0,0, 1,0,1,0,4,1,0));
    // update to 2, with 7 held valid while busy
    tv.push_back(mk(1,1,2, 1,0,1,0,4,0,0));
    tv.push_back(mk(1,1,7, 0,0,0,1,4,0,0));
    tv.push_back(mk(1,1,7, 0,1,0,1,4,0,0));
    tv.push_back(mk(1,1,7, 1,0,0,1,2,0,0));
    tv.push_back(mk(1,1,7, 0,1,0,1,2,0,0));
    tv.push_back(mk(1,1,7, 1,0,0,1,2,0,0));
    tv.push_back(mk(1,1,7, 0,1,0,1,2,0,0));
    tv.push_back(mk(1,1,7, 1,0,1,0,2,0,1));
    tv.push_back(mk(1,0,0, 0,1,0,1,2,0,0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1,0,0, 1,0,0,1,7,0,0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1,0,0, 0,0,0,1,7,0,0));
    tv.push_back(mk(1,0,0, 0,1,0,1,7,0,0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1,0,0, 1,0,0,1,7,0,0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(1,0,0, 0,0,0,1,7,0,0));
    tv.push_back(mk(1,0,0, 0,1,0,1,7,0,0));
    tv.push_back(mk(1,0,0, 1,0,1,0,7,0,1));

    rst_n = 1'b0;
    en = 1'b0;
    cfg.cfg_valid = 1'b0;
    cfg.cfg_div = 8'd0;
    cyc();
    cyc();
    chk("reset_state", 32'(obs()), 32'(pk(0,0,1,0,5,0,0)));
    rst_n = 1'b1;
    cyc();

    foreach (tv[i]) begin
      en = tv[i].en;
      cfg.cfg_valid = tv[i].v;
      cfg.cfg_div = tv[i].div;
      #1;
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(tv[i].exp));
      cyc();
    end

    // en dropped while waiting for the boundary with pend=6
    en = 1'b1;
    cfg.cfg_valid = 1'b1;
    cfg.cfg_div = 8'd6;
    cyc();
    cfg.cfg_valid = 1'b0;
    en = 1'b0;
    #1;
    chk("idle_wait_busy", 32'({busy, tick, div_cur}), 32'({1'b1, 1'b0, 8'd7}));
    cyc();
    chk("idle_load", 32'({div_out, busy, div_cur, cfg.cfg_done}), 32'({1'b0, 1'b1, 8'd6, 1'b0}));
    cyc();
    chk("idle_done", 32'(obs()), 32'(pk(0,0,1,0,6,0,1)));
    en = 1'b1;
    #1;
    chk("restart_tick", 32'(tick), 32'(1));
    cyc();
    for (k = 0; k < 6; k++) begin
      chk($sformatf("restart_k%0d", k), 32'({div_out, tick}), 32'({k < 3, k == 5}));
      cyc();
    end

    // reset in the middle of an update to 3
    cfg.cfg_valid = 1'b1;
    cfg.cfg_div = 8'd3;
    cyc();
    cfg.cfg_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (tick) begin
        got = 1'b1;
        break;
      end
      cyc();
    end
    chk("boundary_seen", 32'(got), 32'(1));
    cyc();
    chk("settle_entered", 32'({busy, div_cur}), 32'({1'b1, 8'd3}));
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({div_out, cfg.cfg_ready, busy, div_cur, cfg.cfg_err, cfg.cfg_done}),
        32'({1'b0, 1'b1, 1'b0, 8'd5, 1'b0, 1'b0}));
    cyc();
    rst_n = 1'b1;
    nd = 0;
    nb = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (cfg.cfg_done) nd++;
      if (busy) nb++;
    end
    chk("no_done_after_reset", 32'(nd), 32'(0));
    chk("no_busy_after_reset", 32'(nb), 32'(0));
    chk("ratio_after_reset", 32'(div_cur), 32'(5));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
